if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and drives the

---
 rtl/if_stage_if.sv | 42 ++++
 rtl/if_stage.sv | 84 ++++++++
 tb/tb_if_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, ROM address/data and the IF/ID register outputs.
// IRQ/IrqAck are present only when FETCH_EXCEPTION_EN is defined.
`default_nettype none

interface if_stage_if;
  logic        Stall;
  logic        Flush;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] InstAddr;
  logic [31:0] Instruction;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
`ifdef FETCH_EXCEPTION_EN
  logic        IRQ;
  logic        IrqAck;
`endif

  // master drives the stage (pipeline control + ROM), slave is the fetch stage itself
  modport master (
    output Stall, Flush, Jump, JumpTarget, BranchTaken, BranchTarget, Instruction,
`ifdef FETCH_EXCEPTION_EN
    output IRQ,
    input  IrqAck,
`endif
    input  InstAddr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
  );

  modport slave (
    input  Stall, Flush, Jump, JumpTarget, BranchTaken, BranchTarget, Instruction,
`ifdef FETCH_EXCEPTION_EN
    input  IRQ,
    output IrqAck,
`endif
    output InstAddr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch - PC register, next-PC selection and IF/ID pipeline register.
// Optional interrupt entry at fetch is enabled by defining FETCH_EXCEPTION_EN.
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.slave  bus
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        irq_taken;
  logic        squash;

  assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_EXCEPTION_EN
  logic irq_ack;

  // PC[31] marks kernel mode; interrupts are not re-entered from the handler
  assign irq_taken = bus.IRQ & ~pc[31];

  always_ff @(posedge clk) begin
    if (reset) irq_ack <= 1'b0;
    else       irq_ack <= irq_taken;
  end

  assign bus.IrqAck = irq_ack;
`else
  logic unused_irq_vector;

  assign irq_taken         = 1'b0;
  assign unused_irq_vector = ^IRQ_VECTOR;
`endif

  assign squash = bus.Flush | bus.BranchTaken | bus.Jump | irq_taken;

  // The branch sits in EX and is older than the jump in ID, so it wins; redirects ignore Stall.
  always_comb begin
    pc_next = pc_plus4;
    if (irq_taken)            pc_next = IRQ_VECTOR;
    else if (bus.BranchTaken) pc_next = bus.BranchTarget;
    else if (bus.Jump)        pc_next = bus.JumpTarget;
    else if (bus.Stall)       pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_pc4   <= 32'h0000_0000;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (squash) begin
      ifid_pc4   <= pc_plus4;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!bus.Stall) begin
      ifid_pc4   <= pc_plus4;
      ifid_instr <= bus.Instruction;
      ifid_valid <= 1'b1;
    end
  end

  assign bus.InstAddr    = pc;
  assign bus.IF_ID_PC4   = ifid_pc4;
  assign bus.IF_ID_Instr = ifid_instr;
  assign bus.IF_ID_Valid = ifid_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, then random control traffic against a
// cycle-level reference model of the fetch rules.
`default_nettype none

module tb_if_stage;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [31:0] rom [0:255];

  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_ack;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .IRQ_VECTOR(IRQ_VECTOR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.Instruction = rom[bus.InstAddr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},  bus.InstAddr, m_pc);
    check({tag, ".pc4"},   bus.IF_ID_PC4, m_pc4);
    check({tag, ".instr"}, bus.IF_ID_Instr, m_instr);
    check({tag, ".valid"}, {31'd0, bus.IF_ID_Valid}, {31'd0, m_valid});
`ifdef FETCH_EXCEPTION_EN
    check({tag, ".ack"},   {31'd0, bus.IrqAck}, {31'd0, m_ack});
`endif
  endtask

  // Reference: what one rising edge does to the architectural state given current inputs.
  task automatic step(input string tag);
    logic [31:0] seq;
    logic [31:0] fetched;
    bit          take_irq;
    bit          kill;
    seq      = m_pc + 32'd4;
    fetched  = rom[m_pc[9:2]];
    take_irq = 1'b0;
`ifdef FETCH_EXCEPTION_EN
    take_irq = bus.IRQ && !m_pc[31];
`endif
    if (reset) begin
      m_pc = RESET_PC; m_pc4 = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0; m_ack = 1'b0;
    end else begin
      kill = bus.Flush || bus.BranchTaken || bus.Jump || take_irq;
      if (kill) begin
        m_pc4 = seq; m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (!bus.Stall) begin
        m_pc4 = seq; m_instr = fetched; m_valid = 1'b1;
      end
      if (take_irq)             m_pc = IRQ_VECTOR;
      else if (bus.BranchTaken) m_pc = bus.BranchTarget;
      else if (bus.Jump)        m_pc = bus.JumpTarget;
      else if (!bus.Stall)      m_pc = seq;
      m_ack = take_irq;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Jump = 1'b0; bus.BranchTaken = 1'b0;
    bus.JumpTarget = 32'd0; bus.BranchTarget = 32'd0;
`ifdef FETCH_EXCEPTION_EN
    bus.IRQ = 1'b0;
`endif
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 7) == 0 ? 1 : 0);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + 32'(i * 7);
    rom[0] = 32'h2004_0003;
    rom[1] = 32'h0c10_0003;
    rom[3] = 32'h23bd_fff8;
    m_pc = 32'hx; m_pc4 = 32'hx; m_instr = 32'hx; m_valid = 1'bx; m_ack = 1'b0;
    idle_inputs();

    // reset for two cycles
    reset = 1'b1;
    step("rst0");
    step("rst1");
    check("rst.addr", bus.InstAddr, 32'h0);
    check("rst.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    check("rst.instr", bus.IF_ID_Instr, 32'h0);

    // free run
    reset = 1'b0;
    step("run0");
    check("run0.instr", bus.IF_ID_Instr, 32'h2004_0003);
    check("run0.pc4", bus.IF_ID_PC4, 32'h4);
    check("run0.valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
    step("run1");
    check("run1.addr", bus.InstAddr, 32'h8);
    check("run1.instr", bus.IF_ID_Instr, 32'h0c10_0003);
    check("run1.pc4", bus.IF_ID_PC4, 32'h8);

    // jump at PC=8
    bus.Jump = 1'b1; bus.JumpTarget = 32'h0C;
    step("jmp");
    check("jmp.addr", bus.InstAddr, 32'h0C);
    check("jmp.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    bus.Jump = 1'b0;
    step("jmp1");
    check("jmp1.instr", bus.IF_ID_Instr, 32'h23bd_fff8);

    // branch and jump together: branch wins
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h08;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h0C;
    step("brj");
    check("brj.addr", bus.InstAddr, 32'h08);
    check("brj.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    idle_inputs();

    // stall at 0x14
    bus.Jump = 1'b1; bus.JumpTarget = 32'h10;
    step("to10");
    bus.Jump = 1'b0;
    step("at14");
    check("at14.addr", bus.InstAddr, 32'h14);
    bus.Stall = 1'b1;
    step("stl0");
    step("stl1");
    check("stl.addr", bus.InstAddr, 32'h14);
    check("stl.pc4", bus.IF_ID_PC4, 32'h14);
    check("stl.valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h20;
    step("stlbr");
    check("stlbr.addr", bus.InstAddr, 32'h20);
    check("stlbr.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    bus.BranchTaken = 1'b0;
    reset = 1'b1;
    step("stlrst");
    check("stlrst.addr", bus.InstAddr, 32'h0);
    idle_inputs();

    // PC+4 wraps
    bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFFC;
    step("wrap0");
    bus.Jump = 1'b0;
    step("wrap1");
    check("wrap.addr", bus.InstAddr, 32'h0);
    check("wrap.pc4", bus.IF_ID_PC4, 32'h0);

`ifdef FETCH_EXCEPTION_EN
    bus.Jump = 1'b1; bus.JumpTarget = 32'h10;
    step("irq_pre");
    bus.Jump = 1'b0;
    bus.IRQ = 1'b1; bus.Stall = 1'b1;
    step("irq0");
    check("irq0.addr", bus.InstAddr, IRQ_VECTOR);
    check("irq0.ack", {31'd0, bus.IrqAck}, 32'd1);
    check("irq0.valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    bus.Stall = 1'b0;
    step("irq1");
    check("irq1.ack", {31'd0, bus.IrqAck}, 32'd0);
    check("irq1.addr", bus.InstAddr, 32'h8000_0008);
    idle_inputs();
`endif

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      reset            = ($urandom_range(0, 39) == 0);
      bus.Stall        = ($urandom_range(0, 3) == 0);
      bus.Flush        = ($urandom_range(0, 9) == 0);
      bus.Jump         = ($urandom_range(0, 7) == 0);
      bus.BranchTaken  = ($urandom_range(0, 9) == 0);
      bus.JumpTarget   = rand_target();
      bus.BranchTarget = rand_target();
`ifdef FETCH_EXCEPTION_EN
      bus.IRQ          = ($urandom_range(0, 9) == 0);
`endif
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

`default_nettype wire
